// File: rtl/compare_sort_sequencer_if.sv
// Producer/consumer bundle for compare_sort_sequencer: packed load word in,
// sorted word and swap count out, with ready/busy/done status.
interface compare_sort_sequencer_if;
    logic        start;
    logic [15:0] Din;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] Q;
    logic [2:0]  SWAPS;

    modport master (output start, Din, input ready, busy, done, Q, SWAPS);
    modport slave  (input start, Din, output ready, busy, done, Q, SWAPS);
endinterface

// File: rtl/compare_sort_sequencer.sv
// Four-element 4-bit bubble sorter sharing one comparator, one compare per clock.
// Optional macro SORT_EARLY_EXIT_EN ends the sort after a pass with no swaps.

module four_bit_comparator (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [2:0] r_o
);
    // r_o = {A>B, A==B, A<B}
    assign r_o = {a_i > b_i, a_i == b_i, a_i < b_i};
endmodule

module compare_sort_sequencer #(
    parameter bit DESCENDING = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    compare_sort_sequencer_if.slave   sort_if
);
    localparam int unsigned EW = 4;
    localparam int unsigned NE = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [NE-1:0][EW-1:0]    elem_q, elem_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [IW-1:0]            last_q, last_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [NE*EW-1:0]         q_q, q_d;
    logic [CW-1:0]            swaps_q, swaps_d;
    logic                     done_q, done_d;
    logic                     ready_q, busy_q;
`ifdef SORT_EARLY_EXIT_EN
    logic                     pass_q, pass_d;
`endif

    logic [IW-1:0]            idx_b;
    logic [EW-1:0]            cmp_a, cmp_b;
    logic [2:0]               cmp_r;
    logic                     do_swap;
    logic                     finish;

    assign idx_b = idx_q + IW'(1);
    assign cmp_a = elem_q[idx_q];
    assign cmp_b = elem_q[idx_b];

    four_bit_comparator u_cmp (
        .a_i (cmp_a),
        .b_i (cmp_b),
        .r_o (cmp_r)
    );

    // Equal operands never swap; direction picks the strict inequality.
    assign do_swap = !cmp_r[1] && (DESCENDING ? cmp_r[0] : cmp_r[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            swaps_q <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
            pass_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            swaps_q <= swaps_d;
            done_q  <= done_d;
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d != S_IDLE);
`ifdef SORT_EARLY_EXIT_EN
            pass_q  <= pass_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        swaps_d = swaps_q;
        done_d  = 1'b0;
        finish  = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
        pass_d  = pass_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (sort_if.start) begin
                    elem_d  = sort_if.Din;
                    idx_d   = '0;
                    last_d  = IW'(2);
                    cnt_d   = '0;
                    state_d = S_CMP;
`ifdef SORT_EARLY_EXIT_EN
                    pass_d  = 1'b0;
`endif
                end
            end
            S_CMP: begin
                if (do_swap) begin
                    elem_d[idx_q] = cmp_b;
                    elem_d[idx_b] = cmp_a;
                    cnt_d         = cnt_q + CW'(1);
`ifdef SORT_EARLY_EXIT_EN
                    pass_d        = 1'b1;
`endif
                end
                if (idx_q != last_q) begin
                    idx_d = idx_b;
                end else if (last_q != '0) begin
                    idx_d  = '0;
                    last_d = last_q - IW'(1);
`ifdef SORT_EARLY_EXIT_EN
                    // A pass with no swaps means the order is final.
                    finish = !(pass_q || do_swap);
                    pass_d = 1'b0;
`else
                    finish = 1'b0;
`endif
                end else begin
                    finish = 1'b1;
                end
                // Publish with the final write-back folded in.
                if (finish) begin
                    state_d = S_DONE;
                    q_d     = elem_d;
                    swaps_d = cnt_d;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sort_if.ready = ready_q;
    assign sort_if.busy  = busy_q;
    assign sort_if.done  = done_q;
    assign sort_if.Q     = q_q;
    assign sort_if.SWAPS = swaps_q;

endmodule

// File: tb/tb_compare_sort_sequencer.sv
// Self-checking bench: ascending and descending instances driven in lockstep,
// checked against a bubble-sort reference model and spec constants.
module tb_compare_sort_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    logic [15:0] prev_a = '0;
    logic [15:0] prev_d = '0;

    compare_sort_sequencer_if if_a ();
    compare_sort_sequencer_if if_d ();

    compare_sort_sequencer #(.DESCENDING(1'b0)) u_asc (.clk(clk), .rst(rst), .sort_if(if_a));
    compare_sort_sequencer #(.DESCENDING(1'b1)) u_dsc (.clk(clk), .rst(rst), .sort_if(if_d));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // Bubble sort over an array; latency is compares issued plus the DONE cycle.
    function automatic void model(input logic [15:0] din, input bit desc,
                                  output logic [15:0] q, output int swaps, output int lat);
        int v[4];
        int cmps = 0;
        swaps = 0;
        for (int i = 0; i < 4; i++) v[i] = int'(din[4*i +: 4]);
        for (int p = 0; p < 3; p++) begin
            int ps = 0;
            for (int j = 0; j < 3 - p; j++) begin
                cmps++;
                if (desc ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
                    int t = v[j];
                    v[j] = v[j+1];
                    v[j+1] = t;
                    ps++;
                    swaps++;
                end
            end
`ifdef SORT_EARLY_EXIT_EN
            if (ps == 0) break;
`endif
        end
        for (int i = 0; i < 4; i++) q[4*i +: 4] = 4'(v[i]);
        lat = cmps + 1;
    endfunction

    task automatic drive(input logic s, input logic [15:0] d);
        if_a.start = s; if_d.start = s;
        if_a.Din = d;   if_d.Din = d;
    endtask

    // Called at a negedge with both DUTs idle; returns at the negedge of cycle 8.
    task automatic do_sort(input logic [15:0] din, input bit extra_start);
        logic [15:0] qa, qd;
        int sa, sd, la, ld;
        int lat_a = 0, lat_d = 0, cnt_a = 0, cnt_d = 0;
        model(din, 1'b0, qa, sa, la);
        model(din, 1'b1, qd, sd, ld);
        drive(1'b1, din);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            drive((extra_start && c == 3) ? 1'b1 : 1'b0, ~din);
            if (c == 1) begin
                check("hold_q_asc", if_a.Q, prev_a);
                check("busy_c1", 16'(if_a.busy), 16'd1);
            end
            if (if_a.done === 1'b1) begin lat_a = c; cnt_a++; end
            if (if_d.done === 1'b1) begin lat_d = c; cnt_d++; end
        end
        @(negedge clk);
        check("lat_asc", 16'(lat_a), 16'(la));
        check("lat_dsc", 16'(lat_d), 16'(ld));
        check("pulses_asc", 16'(cnt_a), 16'd1);
        check("pulses_dsc", 16'(cnt_d), 16'd1);
        check("q_asc", if_a.Q, qa);
        check("q_dsc", if_d.Q, qd);
        check("swaps_asc", 16'(if_a.SWAPS), 16'(sa));
        check("swaps_dsc", 16'(if_d.SWAPS), 16'(sd));
        check("ready_c8", {15'd0, if_a.ready}, 16'd1);
        check("done_c8", {15'd0, if_a.done}, 16'd0);
        prev_a = qa;
        prev_d = qd;
    endtask

    initial begin
        logic [15:0] qx;
        int sx, lx;
        drive(1'b0, 16'h0000);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", {15'd0, if_a.ready}, 16'd1);
        check("rst_busy", {15'd0, if_a.busy}, 16'd0);
        check("rst_done", {15'd0, if_a.done}, 16'd0);
        check("rst_q", if_a.Q, 16'h0000);
        check("rst_swaps", 16'(if_a.SWAPS), 16'd0);

        // Directed cases with spec constants, back-to-back starts.
        do_sort(16'h1739, 1'b0);
        check("dir_asc_q", if_a.Q, 16'h9731);
        check("dir_asc_sw", 16'(if_a.SWAPS), 16'd5);
        check("dir_dsc_q", if_d.Q, 16'h1379);
        check("dir_dsc_sw", 16'(if_d.SWAPS), 16'd1);
        do_sort(16'h5555, 1'b0);
        check("eq_q", if_a.Q, 16'h5555);
        check("eq_sw", 16'(if_a.SWAPS), 16'd0);
        model(16'h5555, 1'b0, qx, sx, lx);
`ifdef SORT_EARLY_EXIT_EN
        check("eq_lat_model", 16'(lx), 16'd4);
`else
        check("eq_lat_model", 16'(lx), 16'd7);
`endif
        do_sort(16'h05AF, 1'b1);
        check("worst_q", if_a.Q, 16'hFA50);
        check("worst_sw", 16'(if_a.SWAPS), 16'd6);

        // Reset at cycle 4 of a sort: no done, outputs cleared.
        drive(1'b1, 16'h1739);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            drive(1'b0, 16'h1739);
            if (c == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", {15'd0, if_a.ready}, 16'd1);
        check("mid_rst_q", if_a.Q, 16'h0000);
        check("mid_rst_sw", 16'(if_d.SWAPS), 16'd0);
        begin
            int seen = 0;
            for (int c = 0; c < 8; c++) begin
                if (if_a.done === 1'b1 || if_d.done === 1'b1) seen++;
                @(negedge clk);
            end
            check("mid_rst_nodone", 16'(seen), 16'd0);
        end
        prev_a = '0;
        prev_d = '0;

        // Randomized sorts against the reference model.
        for (int k = 0; k < 16; k++) begin
            do_sort(16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
